banked_multiport_memory: RTL

Parametrised successor to the fixed 9-read-port memory. It has NUM_PORTS read lanes and one write port over a storage array split into NUM_BANKS interleaved banks. Each bank serves one read per cycle. A batch of lane addresses is accepted by valid/ready handshake, bank conflicts are serialised by a scheduler FSM, and all lane results come back together through a second valid/ready handshake. It is used as the scratchpad between external memory and the PE array.

---
 rtl/banked_multiport_memory_if.sv | 27 ++
 rtl/banked_multiport_memory.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/banked_multiport_memory_if.sv
// Request/response bus of the banked scratchpad: one batch of lane
// addresses in, one batch of lane data words out, each with valid/ready.
interface banked_multiport_memory_if #(
   parameter int WIDTH     = 16,
   parameter int HEIGHT    = 64,
   parameter int NUM_PORTS = 9
);
   localparam int ADDR_W = $clog2(HEIGHT);

   logic                          req_valid;
   logic                          req_ready;
   logic [NUM_PORTS-1:0]          req_mask;
   logic [NUM_PORTS*ADDR_W-1:0]   req_addr;
   logic                          resp_valid;
   logic                          resp_ready;
   logic [NUM_PORTS*WIDTH-1:0]    resp_data;

   modport master (
      output req_valid, req_mask, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_mask, req_addr, resp_ready,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/banked_multiport_memory.sv
// Banked multi-lane scratchpad between external memory and the PE array.
// Words are interleaved over NUM_BANKS banks by the low address bits; each
// bank serves one lane per cycle, so a batch takes as many SERVE cycles as
// its most crowded bank (plus one per write that blocks a needed bank).
module banked_multiport_memory #(
   parameter int WIDTH                = 16,
   parameter int HEIGHT               = 64,
   parameter int NUM_PORTS            = 9,
   parameter int NUM_BANKS            = 4,
   parameter int USED_AS_EXTERNAL_MEM = 0,
   localparam int ADDR_W              = $clog2(HEIGHT)
) (
   input  logic                        clk,
   input  logic                        arst_n_in,
   banked_multiport_memory_if.slave    bus,
   input  logic                        write_en,
   input  logic [ADDR_W-1:0]           write_addr,
   input  logic [WIDTH-1:0]            din,
   output logic [31:0]                 conflict_count
);

   localparam int ROWS   = HEIGHT / NUM_BANKS;
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int LANE_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SERVE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   // The cost-model flag only matters to the simulation environment; the
   // storage itself is identical for both uses.
   if (USED_AS_EXTERNAL_MEM != 0) begin : g_external_use
   end

   function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
      return BANK_W'(a % ADDR_W'(NUM_BANKS));
   endfunction

   function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
      return ROW_W'(a / ADDR_W'(NUM_BANKS));
   endfunction

   logic [1:0]            state;
   logic [NUM_PORTS-1:0]  pending;
   logic [NUM_PORTS-1:0]  lane_grant;
   logic [NUM_PORTS-1:0]  still_pending;
   logic [ADDR_W-1:0]     lane_addr [NUM_PORTS];
   logic [WIDTH-1:0]      lane_data [NUM_PORTS];

   logic [WIDTH-1:0]      bank_mem  [NUM_BANKS][ROWS];
   logic                  bank_hit  [NUM_BANKS];
   logic [LANE_W-1:0]     bank_lane [NUM_BANKS];
   logic [WIDTH-1:0]      bank_rd   [NUM_BANKS];
   logic [BANK_W-1:0]     write_bank;

   assign write_bank     = bank_of(write_addr);
   assign bus.req_ready  = (state == ST_IDLE);
   assign bus.resp_valid = (state == ST_RESP);

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_resp_pack
      assign bus.resp_data[p*WIDTH +: WIDTH] = lane_data[p];
   end

   // Per-bank arbiter: a bank being written this cycle stays idle, otherwise
   // the lowest-numbered pending lane that maps onto the bank wins.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_hit[b]  = 1'b0;
         bank_lane[b] = '0;
      end
      if (state == ST_SERVE) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (!(write_en && write_bank == BANK_W'(b))) begin
               for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                  if (pending[p] && bank_of(lane_addr[p]) == BANK_W'(b)) begin
                     bank_hit[b]  = 1'b1;
                     bank_lane[b] = LANE_W'(p);
                  end
               end
            end
         end
      end
   end

   // One read per bank, addressed by whichever lane that bank granted.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_rd[b] = bank_mem[b][row_of(lane_addr[bank_lane[b]])];
      end
   end

   // Fan the bank grants back out to lanes and work out who is still waiting.
   always_comb begin
      lane_grant = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         lane_grant[p] = bank_hit[bank_of(lane_addr[p])] &&
                         (bank_lane[bank_of(lane_addr[p])] == LANE_W'(p));
      end
      still_pending = pending & ~lane_grant;
   end

   // Batch sequencing: accept in IDLE, drain lanes in SERVE, hold results in RESP.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state          <= ST_IDLE;
         pending        <= '0;
         conflict_count <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            lane_data[p] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  pending <= bus.req_mask;
                  for (int p = 0; p < NUM_PORTS; p++) begin
                     lane_data[p] <= '0;
                  end
                  state <= (|bus.req_mask) ? ST_SERVE : ST_RESP;
               end
            end
            ST_SERVE: begin
               pending <= still_pending;
               for (int p = 0; p < NUM_PORTS; p++) begin
                  if (lane_grant[p]) begin
                     lane_data[p] <= bank_rd[bank_of(lane_addr[p])];
                  end
               end
               if (|still_pending) begin
                  if (conflict_count != 32'hFFFF_FFFF) begin
                     conflict_count <= conflict_count + 32'd1;
                  end
               end else begin
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Lane addresses are captured with the batch and need no reset.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && bus.req_valid) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            lane_addr[p] <= bus.req_addr[p*ADDR_W +: ADDR_W];
         end
      end
   end

   // Write port is never stalled; the arbiter keeps reads off the written bank.
   always_ff @(posedge clk) begin
      if (write_en) begin
         bank_mem[write_bank][row_of(write_addr)] <= din;
      end
   end

endmodule
